// File: rtl/conc_stim_player.sv
// Stimulus sequencer: replays a writable program of {repeat, obs, stim} entries
// onto the DUT inputs, with per-entry repeat counts, one-shot/loop modes and a done pulse.
module conc_stim_player #(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int REPW  = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [REPW+NCH:0]       wr_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_mode,
  input  logic [AW:0]             len,
  output logic [NCH-1:0]          stim,
  output logic                    obs,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           pc,
  output logic [7:0]              loops
);

  localparam int EW = REPW + NCH + 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Program memory is never cleared; only written through the wr_* port.
  logic [EW-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [NCH-1:0]    stim_q, stim_d;
  logic              obs_q, obs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [7:0]        loops_q, loops_d;
  logic [REPW-1:0]   rep_q, rep_d;
  logic              mode_q, mode_d;
  logic [AW:0]       len_q, len_d;

  logic [AW:0]       len_eff;
  logic              start_ok;
  logic              at_last;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_word;
  logic [REPW-1:0]   rd_rep;
  logic              rd_obs;
  logic [NCH-1:0]    rd_stim;
  logic [7:0]        loops_inc;

  always_ff @(posedge clock) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign len_eff   = (len > DEPTH_W) ? DEPTH_W : len;
  assign start_ok  = start && (len != '0);
  assign at_last   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign loops_inc = (loops_q != 8'hFF) ? (loops_q + 8'd1) : loops_q;

  // Only one entry is ever loaded per edge: entry 0 on start/wrap, else pc+1.
  always_comb begin
    rd_addr = '0;
    if (state_q == RUN && !at_last) begin
      rd_addr = pc_q + AW'(1);
    end
  end

  assign rd_word = mem_q[rd_addr];
  assign rd_rep  = rd_word[EW-1:NCH+1];
  assign rd_obs  = rd_word[NCH];
  assign rd_stim = rd_word[NCH-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop is only examined in RUN, so start wins in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rep_q == '0 && at_last && !mode_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    stim_d  = stim_q;
    obs_d   = obs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    loops_d = loops_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          stim_d  = rd_stim;
          obs_d   = rd_obs;
          rep_d   = rd_rep;
          busy_d  = 1'b1;
          pc_d    = '0;
          loops_d = '0;
          mode_d  = loop_mode;
          len_d   = len_eff;
        end
      end
      RUN: begin
        if (stop) begin
          stim_d = '0;
          obs_d  = 1'b0;
          busy_d = 1'b0;
        end else if (rep_q != '0) begin
          rep_d = rep_q - REPW'(1);
        end else if (!at_last) begin
          pc_d   = pc_q + AW'(1);
          stim_d = rd_stim;
          obs_d  = rd_obs;
          rep_d  = rd_rep;
        end else if (!mode_q) begin
          stim_d = '0;
          obs_d  = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          pc_d    = '0;
          stim_d  = rd_stim;
          obs_d   = rd_obs;
          rep_d   = rd_rep;
          loops_d = loops_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stim_q  <= '0;
      obs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      loops_q <= '0;
      rep_q   <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      stim_q  <= stim_d;
      obs_q   <= obs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      loops_q <= loops_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
    end
  end

  assign stim  = stim_q;
  assign obs   = obs_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pc    = pc_q;
  assign loops = loops_q;

endmodule

// File: doc/conc_stim_player.md
# conc_stim_player

Synthesizable, parametrised stimulus sequencer for the concolic test harness. It replays a program of stimulus words from an internal, writable memory onto the DUT input lines and the `__obs` observation line, one word per step. It adds per-entry repeat counts, one-shot/loop modes, start/stop control and a done pulse. It sits between the harness loader and the DUT top instance, replacing the free-running program-counter stimulus driver.

## Interface

Parameters:
- NCH, 2, number of stimulus channels driven to the DUT
- DEPTH, 16, program memory entries (≥2)
- REPW, 4, repeat-count field width
- AW, $clog2(DEPTH), address width (derived)

Entry format, `EW = REPW+NCH+1` bits:
- [EW-1:NCH+1] repeat count
- [NCH] obs bit
- [NCH-1:0] stimulus bits

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  program memory write strobe
- wr_addr  in  AW  write address
- wr_data  in  EW  entry to write
- start  in  1  start request; honoured only in IDLE
- stop  in  1  abort request
- loop_mode  in  1  0 = one-shot, 1 = loop; sampled at start
- len  in  AW+1  program length in entries; sampled at start
- stim  out  NCH  registered stimulus to DUT
- obs  out  1  registered observation bit (`__obs`)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at one-shot completion
- pc  out  AW  index of the entry currently driven
- loops  out  8  completed passes in loop mode, saturating at 255

## Operation

- States: IDLE, RUN.
- Reset (synchronous):
  - state = IDLE; stim = 0; obs = 0; busy = 0; done = 0; pc = 0; loops = 0.
  - Memory contents are not cleared.
- Writes:
  - wr_en writes mem[wr_addr] on the edge, in any state.
  - A write to an entry takes effect the next time that entry is loaded.
  - wr_addr ≥ DEPTH is ignored.
- Length: len_eff = min(len, DEPTH), latched at start.
- Start in IDLE:
  - Ignored if len = 0.
  - Otherwise the edge loads entry 0: stim/obs ← mem[0] fields, rep ← mem[0].repeat.
  - Also on that edge: pc ← 0, loops ← 0, latch mode and len_eff, state → RUN, busy ← 1.
- Each RUN edge, in priority order:
  1. stop=1: state → IDLE; stim, obs, busy ← 0; no done pulse; pc and loops hold.
  2. rep ≠ 0: rep decrements; outputs hold.
  3. pc ≠ len_eff−1: pc increments; load entry pc+1.
  4. pc = len_eff−1, one-shot: state → IDLE; stim, obs, busy ← 0; done ← 1 for one cycle.
  5. pc = len_eff−1, loop: pc ← 0; load entry 0; loops increments, saturating at 255.
- Each entry is therefore driven for repeat+1 cycles.
- start while in RUN is ignored.
- stop while in IDLE has no effect.
- Simultaneous start and stop in IDLE: start wins (stop is only examined in RUN).
- Reset beats every other input. Reset mid-RUN returns to IDLE with outputs cleared and no done pulse.

## Timing

- Start latency: start sampled at edge k → stim = mem[0] and busy = 1 from edge k.
- Step rate: one entry per cycle when repeat = 0.
- One-shot total busy time = Σ(repeat_i + 1) over entries 0..len_eff−1.
  - done asserts on the edge where busy falls, and clears on the next edge.
- Restart: a start in the same cycle that done is high is accepted, because state is already IDLE.
- Loop wrap: no bubble; entry 0 follows the last entry on the next edge.
- Memory read is combinational from the register array; all outputs are registered. No output depends combinationally on any input.

## Test plan

- Reset, then one-shot run:
  - Stimulus: NCH=2, mem = {rep0:stim 01 obs0, rep0:stim 10 obs1, rep0:stim 11 obs0}, len=3, start.
  - Required: stim = 01, 10, 11 on three consecutive cycles; obs = 0, 1, 0; done high exactly one cycle after the third word; then stim = 0 and busy = 0.
- Repeat counts:
  - Stimulus: entry 0 rep=3 stim=10, entry 1 rep=0 stim=01, len=2.
  - Required: stim = 10 for 4 cycles, then 01 for 1 cycle; busy high for 5 cycles.
- Loop mode:
  - Stimulus: len=2, loop_mode=1, run 7 cycles, then stop.
  - Required: stim alternates with no gap; loops increments on each wrap to entry 0 (final value 3); after stop, busy = 0 and done never pulses.
- Boundaries:
  - len=0 with start: busy stays 0.
  - len=DEPTH+5: exactly DEPTH entries are played.
  - start pulsed while busy: the sequence is unaffected.
- Live rewrite and reset:
  - Rewrite entry 1 while entry 0 (rep=2) is being driven: the new value appears when entry 1 is loaded.
  - Reset asserted mid-RUN: all outputs are 0 the next cycle; loops and pc are 0; no done pulse.
